// File: rtl/axi_line_master.sv
// axi_line_master
//
// Cache-line AXI4 master. Turns one line refill or line writeback request
// from the cache controller into a single AXI4 read or write burst, then
// returns the assembled line (refill) or a completion (writeback) with an
// error flag. Only one transaction is outstanding at a time. AXI addresses
// are always issued before any data beat.
//
// Optional feature (compile-time macro):
//   AXI_LINE_MASTER_WRAP_EN - refills use WRAP bursts starting at the
//   beat that holds req_addr (critical word first). Writebacks stay INCR.
//   When the macro is undefined, every burst is INCR from the line base.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake from the cache
//   req_write                  1 = writeback, 0 = refill
//   req_addr                   byte address inside the target line
//   req_wdata, req_wmask       writeback line data and byte enables
//   rsp_valid/rsp_ready        response handshake to the cache
//   rsp_rdata, rsp_err         refill line (line order) and error flag
//   aw_*, w_*, b_*             AXI write address / data / response channels
//   ar_*, r_*                  AXI read address / data channels

module axi_line_master #(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int LINE_BYTES     = 64,
    parameter int MASTER_ID      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_BYTES*8-1:0]     req_wdata,
    input  logic [LINE_BYTES-1:0]       req_wmask,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [LINE_BYTES*8-1:0]     rsp_rdata,
    output logic                        rsp_err,

    output logic                        aw_valid,
    input  logic                        aw_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    output logic [7:0]                  aw_len,
    output logic [2:0]                  aw_size,
    output logic [1:0]                  aw_burst,
    output logic [AXI_ID_WIDTH-1:0]     aw_id,

    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [AXI_DATA_WIDTH-1:0]   w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    output logic                        w_last,

    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [1:0]                  b_resp,

    output logic                        ar_valid,
    input  logic                        ar_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    output logic [7:0]                  ar_len,
    output logic [2:0]                  ar_size,
    output logic [1:0]                  ar_burst,
    output logic [AXI_ID_WIDTH-1:0]     ar_id,

    input  logic                        r_valid,
    output logic                        r_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data,
    input  logic [1:0]                  r_resp,
    input  logic                        r_last
);

    localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int LINE_BITS  = LINE_BYTES * 8;

    localparam logic [BEAT_BITS-1:0]      LAST_BEAT  = BEAT_BITS'(BEATS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_ALIGN = ~(AXI_ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [1:0]                BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RESP
    } state_t;

    state_t                    state;
    state_t                    next_state;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]      wdata_q;
    logic [LINE_BYTES-1:0]     wmask_q;
    logic [LINE_BITS-1:0]      line_buf;
    logic [BEAT_BITS-1:0]      cnt;
    logic [BEAT_BITS-1:0]      slot;
    logic                      err;
    logic                      last;

    assign last = (cnt == LAST_BEAT);

`ifdef AXI_LINE_MASTER_WRAP_EN
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_ALIGN = ~(AXI_ADDR_WIDTH'(BEAT_BYTES - 1));
    localparam logic [1:0]                BURST_WRAP = 2'b10;

    logic [BEAT_BITS-1:0] start_beat;

    // The wrap burst begins at the beat holding req_addr; rotate each beat
    // back to its natural slot so the returned line stays in line order.
    // The mask keeps the single-beat case pinned to slot 0.
    assign start_beat = BEAT_BITS'((addr_q >> BEAT_SHIFT) & AXI_ADDR_WIDTH'(BEATS - 1));
    assign slot       = (start_beat + cnt) & LAST_BEAT;
    assign ar_addr    = addr_q & BEAT_ALIGN;
    assign ar_burst   = BURST_WRAP;
`else
    assign slot       = cnt;
    assign ar_addr    = addr_q & LINE_ALIGN;
    assign ar_burst   = BURST_INCR;
`endif

    assign ar_len    = 8'(BEATS - 1);
    assign ar_size   = 3'(BEAT_SHIFT);
    assign ar_id     = AXI_ID_WIDTH'(MASTER_ID);

    assign aw_addr   = addr_q & LINE_ALIGN;
    assign aw_len    = 8'(BEATS - 1);
    assign aw_size   = 3'(BEAT_SHIFT);
    assign aw_burst  = BURST_INCR;
    assign aw_id     = AXI_ID_WIDTH'(MASTER_ID);

    assign w_data    = wdata_q[cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_strb    = wmask_q[cnt*BEAT_BYTES +: BEAT_BYTES];

    assign rsp_rdata = line_buf;
    assign rsp_err   = err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every handshake output is a pure decode of the state register, so no
    // input ready/valid ever reaches an output valid combinationally.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        ar_valid   = 1'b0;
        r_ready    = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = req_write ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (r_valid && last) begin
                    next_state = RESP;
                end
            end
            WR_ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) begin
                    next_state = WR_DATA;
                end
            end
            WR_DATA: begin
                w_valid = 1'b1;
                w_last  = last;
                if (w_ready && last) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, beat counting, line assembly and error accumulation.
    // The counter returns to zero on the final beat so it never wraps
    // mid-burst and is ready for the next transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            line_buf <= '0;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        cnt     <= '0;
                        err     <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (r_valid) begin
                        line_buf[slot*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= r_data;
                        err <= err | (r_resp != 2'b00) | (r_last != last);
                        cnt <= last ? '0 : cnt + BEAT_BITS'(1);
                    end
                end
                WR_DATA: begin
                    if (w_ready) begin
                        cnt <= last ? '0 : cnt + BEAT_BITS'(1);
                    end
                end
                WR_RESP: begin
                    if (b_valid) begin
                        err <= err | (b_resp != 2'b00);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master
//
// Self-checking bench for axi_line_master with default parameters
// (256-bit data, 64-byte lines, two beats per line). The bench plays the
// AXI slave and the cache, using random addresses and data, and predicts
// every AXI field and response from a line-level model of the protocol.
// Honours AXI_LINE_MASTER_WRAP_EN when predicting refill address and order.

module tb_axi_line_master;

    localparam int DW         = 256;
    localparam int AW         = 64;
    localparam int IDW        = 4;
    localparam int LB         = 64;
    localparam int BEAT_BYTES = DW / 8;
    localparam int BEATS      = LB / BEAT_BYTES;
    localparam int LINE_BITS  = LB * 8;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [AW-1:0]         req_addr;
    logic [LINE_BITS-1:0]  req_wdata;
    logic [LB-1:0]         req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LINE_BITS-1:0]  rsp_rdata;
    logic                  rsp_err;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [AW-1:0]         aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic [IDW-1:0]        aw_id;
    logic                  w_valid;
    logic                  w_ready;
    logic [DW-1:0]         w_data;
    logic [DW/8-1:0]       w_strb;
    logic                  w_last;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [AW-1:0]         ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic [IDW-1:0]        ar_id;
    logic                  r_valid;
    logic                  r_ready;
    logic [DW-1:0]         r_data;
    logic [1:0]            r_resp;
    logic                  r_last;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_line_master #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AW),
        .AXI_ID_WIDTH   (IDW),
        .LINE_BYTES     (LB),
        .MASTER_ID      (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .aw_addr   (aw_addr),
        .aw_len    (aw_len),
        .aw_size   (aw_size),
        .aw_burst  (aw_burst),
        .aw_id     (aw_id),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_strb    (w_strb),
        .w_last    (w_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_resp    (b_resp),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_size   (ar_size),
        .ar_burst  (ar_burst),
        .ar_id     (ar_id),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_last    (r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] v;
        for (int i = 0; i < LINE_BITS / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom, $urandom};
    endfunction

    // Reference model: where a refill starts and where beat k lands in the line.
    function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
        return a - (a % LB);
    endfunction

    function automatic logic [AW-1:0] exp_raddr(input logic [AW-1:0] a);
`ifdef AXI_LINE_MASTER_WRAP_EN
        return a - (a % BEAT_BYTES);
`else
        return line_base(a);
`endif
    endfunction

    function automatic logic [1:0] exp_rburst();
`ifdef AXI_LINE_MASTER_WRAP_EN
        return 2'b10;
`else
        return 2'b01;
`endif
    endfunction

    function automatic int exp_slot(input logic [AW-1:0] a, input int k);
`ifdef AXI_LINE_MASTER_WRAP_EN
        return (int'((a / BEAT_BYTES) % BEATS) + k) % BEATS;
`else
        return k;
`endif
    endfunction

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        b_resp    = 2'b00;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_resp    = 2'b00;
        r_last    = 1'b0;
    endtask

    // One full refill. Starts and ends on a falling edge so calls chain
    // back to back. During rsp backpressure a competing request is offered
    // and must not be taken.
    task automatic run_refill(input logic [AW-1:0] addr, input int ar_delay,
                              input int rsp_delay, input int err_beat,
                              input bit bad_last, input string name);
        logic [DW-1:0]        beat;
        logic [LINE_BITS-1:0] exp_line;
        logic                 exp_err;
        exp_line  = '0;
        exp_err   = ((err_beat >= 0) && (err_beat < BEATS)) || bad_last;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = rand_line();
        req_wmask = {$urandom, $urandom};
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s req_ready: got %b want 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c <= ar_delay; c++) begin
            tests_run++;
            if ({ar_valid, req_ready, r_ready, ar_addr, ar_len, ar_size, ar_burst, ar_id} !==
                {1'b1, 1'b0, 1'b0, exp_raddr(addr), 8'(BEATS - 1), 3'd5, exp_rburst(), 4'd0}) begin
                tests_failed++;
                $display("[TB] FAIL %s ar cycle %0d: got valid=%b rdy=%b addr=%h len=%0d size=%0d burst=%b id=%0d want addr=%h burst=%b",
                         name, c, ar_valid, req_ready, ar_addr, ar_len, ar_size, ar_burst, ar_id,
                         exp_raddr(addr), exp_rburst());
            end
            if (c == ar_delay) ar_ready = 1'b1;
            @(negedge clk);
        end
        ar_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            beat    = rand_beat();
            r_valid = 1'b1;
            r_data  = beat;
            r_resp  = (k == err_beat) ? 2'b10 : 2'b00;
            r_last  = (k == BEATS - 1) ? !bad_last : 1'b0;
            exp_line[exp_slot(addr, k)*DW +: DW] = beat;
            tests_run++;
            if ({r_ready, ar_valid, rsp_valid} !== 3'b100) begin
                tests_failed++;
                $display("[TB] FAIL %s r beat %0d: got r_ready=%b ar_valid=%b rsp_valid=%b want 1 0 0",
                         name, k, r_ready, ar_valid, rsp_valid);
            end
            @(negedge clk);
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
        for (int c = 0; c <= rsp_delay; c++) begin
            tests_run++;
            if ({rsp_valid, rsp_err, req_ready, r_ready, rsp_rdata} !== {1'b1, exp_err, 1'b0, 1'b0, exp_line}) begin
                tests_failed++;
                $display("[TB] FAIL %s rsp cycle %0d: got valid=%b err=%b rdy=%b data=%h want err=%b data=%h",
                         name, c, rsp_valid, rsp_err, req_ready, rsp_rdata, exp_err, exp_line);
            end
            if (c < rsp_delay) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = rand_addr();
            end else begin
                req_valid = 1'b0;
                rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, req_ready, aw_valid, ar_valid} !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL %s after rsp: got rsp_valid=%b req_ready=%b aw_valid=%b ar_valid=%b want 0 1 0 0",
                     name, rsp_valid, req_ready, aw_valid, ar_valid);
        end
    endtask

    // One full writeback; the request line is scrambled after the
    // handshake so the W beats must come from the captured copy.
    task automatic run_write(input logic [AW-1:0] addr, input logic [LB-1:0] mask,
                             input int aw_delay, input bit b_err, input string name);
        logic [LINE_BITS-1:0] line;
        line      = rand_line();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = line;
        req_wmask = mask;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s req_ready: got %b want 1", name, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = rand_line();
        req_wmask = ~mask;
        req_addr  = rand_addr();
        for (int c = 0; c <= aw_delay; c++) begin
            tests_run++;
            if ({aw_valid, w_valid, ar_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id} !==
                {1'b1, 1'b0, 1'b0, line_base(addr), 8'(BEATS - 1), 3'd5, 2'b01, 4'd0}) begin
                tests_failed++;
                $display("[TB] FAIL %s aw cycle %0d: got valid=%b w_valid=%b addr=%h len=%0d size=%0d burst=%b want addr=%h",
                         name, c, aw_valid, w_valid, aw_addr, aw_len, aw_size, aw_burst, line_base(addr));
            end
            if (c == aw_delay) aw_ready = 1'b1;
            @(negedge clk);
        end
        aw_ready = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            tests_run++;
            if ({w_valid, aw_valid, w_last, w_strb, w_data} !==
                {1'b1, 1'b0, (k == BEATS - 1), mask[k*BEAT_BYTES +: BEAT_BYTES], line[k*DW +: DW]}) begin
                tests_failed++;
                $display("[TB] FAIL %s w beat %0d: got valid=%b last=%b strb=%h data=%h want last=%b strb=%h data=%h",
                         name, k, w_valid, w_last, w_strb, w_data, (k == BEATS - 1),
                         mask[k*BEAT_BYTES +: BEAT_BYTES], line[k*DW +: DW]);
            end
            w_ready = 1'b1;
            @(negedge clk);
        end
        w_ready = 1'b0;
        tests_run++;
        if ({b_ready, w_valid, rsp_valid} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL %s b phase: got b_ready=%b w_valid=%b rsp_valid=%b want 1 0 0",
                     name, b_ready, w_valid, rsp_valid);
        end
        b_valid = 1'b1;
        b_resp  = b_err ? 2'b10 : 2'b00;
        @(negedge clk);
        b_valid = 1'b0;
        b_resp  = 2'b00;
        tests_run++;
        if ({rsp_valid, rsp_err, b_ready} !== {1'b1, b_err, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL %s write rsp: got valid=%b err=%b b_ready=%b want 1 %b 0",
                     name, rsp_valid, rsp_err, b_ready, b_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL %s after rsp: got rsp_valid=%b req_ready=%b want 0 1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, rsp_err, rsp_rdata} !==
            {1'b1, 7'b0, {LINE_BITS{1'b0}}}) begin
            tests_failed++;
            $display("[TB] FAIL reset state: got req_ready=%b ar=%b aw=%b w=%b r=%b b=%b rsp=%b err=%b data=%h",
                     req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_refill();
        run_refill(64'h1000, 0, 0, -1, 1'b0, "refill_0x1000");
`ifdef AXI_LINE_MASTER_WRAP_EN
        run_refill(64'h1020, 0, 0, -1, 1'b0, "refill_wrap_0x1020");
`endif
        for (int i = 0; i < 4; i++) begin
            run_refill(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 2), -1, 1'b0, "refill_rand");
        end
    endtask

    task automatic test_writeback();
        run_write(64'h2040, {LB{1'b1}}, 0, 1'b0, "write_0x2040");
        for (int i = 0; i < 3; i++) begin
            run_write(rand_addr(), {$urandom, $urandom}, $urandom_range(0, 2), 1'b0, "write_rand");
        end
    endtask

    task automatic test_errors();
        run_refill(rand_addr(), 0, 0, 0, 1'b0, "refill_slverr_beat0");
        run_refill(rand_addr(), 0, 0, BEATS - 1, 1'b0, "refill_slverr_last");
        run_refill(rand_addr(), 0, 0, -1, 1'b1, "refill_missing_last");
        run_write(rand_addr(), {$urandom, $urandom}, 0, 1'b1, "write_bresp_err");
        run_refill(rand_addr(), 0, 0, -1, 1'b0, "refill_err_cleared");
    endtask

    task automatic test_backpressure();
        run_refill(rand_addr(), 5, 3, -1, 1'b0, "refill_backpressure");
        run_write(rand_addr(), {$urandom, $urandom}, 4, 1'b0, "write_backpressure");
    endtask

    task automatic test_reset_mid_write();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = rand_addr();
        req_wdata = rand_line();
        req_wmask = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1'b0;
        aw_ready  = 1'b1;
        @(negedge clk);
        aw_ready  = 1'b0;
        w_ready   = 1'b1;
        @(negedge clk);
        w_ready   = 1'b0;
        tests_run++;
        if ({w_valid, w_last} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL mid_write beat1: got w_valid=%b w_last=%b want 1 1", w_valid, w_last);
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, rsp_err, rsp_rdata} !==
            {1'b1, 7'b0, {LINE_BITS{1'b0}}}) begin
            tests_failed++;
            $display("[TB] FAIL mid_write reset: got req_ready=%b aw=%b w=%b b=%b rsp=%b err=%b data=%h",
                     req_ready, aw_valid, w_valid, b_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_write(rand_addr(), {$urandom, $urandom}, 0, 1'b0, "write_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_write(rand_addr(), {$urandom, $urandom}, 0, 1'b0, "b2b_write");
            end else begin
                run_refill(rand_addr(), 0, 0, -1, 1'b0, "b2b_refill");
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_refill();
        test_writeback();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
